// File: rtl/float16_accum_ctrl.sv
// float16 vector accumulator: folds a stream of float16 terms into one sum
// through a single combinational float16_adder, result on a valid/ready port.
module float16_adder (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] y_o
);
  logic [4:0]  ea, eb, e_big, e_sml, diff;
  logic [10:0] ma, mb, m_big, m_sml, m_aln, m_nrm;
  logic        a_big, s_big;
  logic [11:0] sum;
  logic [3:0]  lz;

  // Exponent 0 (zero or subnormal) carries no hidden bit and reads as +0.
  assign ea    = a_i[14:10];
  assign eb    = b_i[14:10];
  assign ma    = (ea == 5'd0) ? 11'd0 : {1'b1, a_i[9:0]};
  assign mb    = (eb == 5'd0) ? 11'd0 : {1'b1, b_i[9:0]};
  assign a_big = (ea > eb) || ((ea == eb) && (ma >= mb));
  assign e_big = a_big ? ea : eb;
  assign e_sml = a_big ? eb : ea;
  assign m_big = a_big ? ma : mb;
  assign m_sml = a_big ? mb : ma;
  assign s_big = a_big ? a_i[15] : b_i[15];
  assign diff  = e_big - e_sml;
  assign m_aln = m_sml >> diff;
  assign sum   = (a_i[15] == b_i[15]) ?
                 {1'b0, m_big} + {1'b0, m_aln} :
                 {1'b0, m_big} - {1'b0, m_aln};

  always_comb begin
    lz = 4'd0;
    for (int i = 0; i <= 10; i++)
      if (sum[i]) lz = 4'(10 - i);
  end

  assign m_nrm = sum[10:0] << lz;

  always_comb begin
    y_o = 16'h0000;
    if (sum[11])
      y_o = {s_big, e_big + 5'd1, sum[10:1]};
    else if (sum != 12'd0 && {1'b0, e_big} > {2'b00, lz})
      y_o = {s_big, e_big - {1'b0, lz}, m_nrm[9:0]};
  end
endmodule

module float16_accum_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [15:0]      out_data,
  input  logic             out_ready,
  output logic [LEN_W-1:0] count
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      acc_q, acc_d, sum;
  logic [LEN_W-1:0] count_q, count_d, len_q, len_d, count_inc;

  float16_adder u_add (
    .a_i (acc_q),
    .b_i (in_data),
    .y_o (sum)
  );

  assign count_inc = count_q + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= 16'h0000;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    len_d   = len_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = 16'h0000;
          count_d = '0;
          len_d   = len;
          state_d = (len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        // abort wins over a beat landing in the same cycle
        if (abort) begin
          acc_d   = 16'h0000;
          state_d = S_IDLE;
        end else if (in_valid) begin
          acc_d   = sum;
          count_d = count_inc;
          if (count_inc == len_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = acc_q;
  assign count     = count_q;
endmodule

// File: tb/tb_float16_accum_ctrl.sv
// Directed vector table, hand-written corner sequences and a random
// regression against an independent float16 fold model.
module tb_float16_accum_ctrl;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst, start, abort, in_valid, out_ready;
  logic             busy, in_ready, out_valid;
  logic [LEN_W-1:0] len, count;
  logic [15:0]      in_data, out_data;

  float16_accum_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [15:0] t0, t1, t2, t3;
    logic [15:0] exp;
  } vec_t;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] terms [256];
  vec_t        tbl [12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Value-level model: align on the larger exponent's grid, truncate.
  function automatic logic [15:0] m_add(logic [15:0] a, logic [15:0] b);
    int ea, eb, ma, mb, e, s, mag;
    bit neg;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ma = (ea == 0) ? 0 : 1024 + int'(a[9:0]);
    mb = (eb == 0) ? 0 : 1024 + int'(b[9:0]);
    e  = (ea > eb) ? ea : eb;
    ma = ma >> (e - ea);
    mb = mb >> (e - eb);
    s  = (a[15] ? -ma : ma) + (b[15] ? -mb : mb);
    if (s == 0) return 16'h0000;
    neg = (s < 0);
    mag = neg ? -s : s;
    while (mag >= 2048) begin
      mag = mag >> 1;
      e++;
    end
    while (mag < 1024) begin
      mag = mag << 1;
      e--;
      if (e <= 0) return 16'h0000;
    end
    return {neg, 5'(e), 10'(mag - 1024)};
  endfunction

  task automatic run_vec(input int n, input bit gaps,
                         output logic [15:0] res, output int cyc,
                         output int cnt);
    int idx;
    bit got;
    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(n);
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    idx = 0;
    got = 1'b0;
    res = 16'h0000;
    cnt = 0;
    while (!got && cyc < 3000) begin
      if (out_valid) begin
        got = 1'b1;
        res = out_data;
        cnt = int'(count);
      end else begin
        in_valid = (idx < n) && (!gaps || $urandom_range(0, 2) != 0);
        in_data  = terms[idx % 256];
        if (in_valid && in_ready) idx++;
        @(negedge clk);
        cyc++;
      end
    end
    in_valid = 1'b0;
    chk("out_valid_seen", 32'(got), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_out_valid", 32'(out_valid), 32'd0);
    chk("hs_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] res, mexp;
    int cyc, cnt, n;

    tbl[0]  = '{4, 16'h3C00, 16'h4000, 16'h4200, 16'h3800, 16'h4680};
    tbl[1]  = '{2, 16'h3C00, 16'hBC00, 16'h0, 16'h0, 16'h0000};
    tbl[2]  = '{1, 16'h8001, 16'h0, 16'h0, 16'h0, 16'h0000};
    tbl[3]  = '{0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000};
    tbl[4]  = '{2, 16'h4200, 16'hC000, 16'h0, 16'h0, 16'h3C00};
    tbl[5]  = '{2, 16'h3C00, 16'h1400, 16'h0, 16'h0, 16'h3C01};
    tbl[6]  = '{2, 16'h3C00, 16'h1000, 16'h0, 16'h0, 16'h3C00};
    tbl[7]  = '{3, 16'h3C00, 16'h1400, 16'hBC00, 16'h0, 16'h1400};
    tbl[8]  = '{2, 16'h0400, 16'h8401, 16'h0, 16'h0, 16'h0000};
    tbl[9]  = '{2, 16'h3C00, 16'h0001, 16'h0, 16'h0, 16'h3C00};
    tbl[10] = '{3, 16'h7800, 16'h7800, 16'h3C00, 16'h0, 16'h7C00};
    tbl[11] = '{3, 16'h3C00, 16'h1400, 16'h3C00, 16'h0, 16'h4000};

    rst = 1'b1; start = 1'b0; abort = 1'b0; len = '0;
    in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);

    for (int v = 0; v < 12; v++) begin
      terms[0] = tbl[v].t0;
      terms[1] = tbl[v].t1;
      terms[2] = tbl[v].t2;
      terms[3] = tbl[v].t3;
      run_vec(tbl[v].n, 1'b0, res, cyc, cnt);
      chk($sformatf("vec%0d_data", v), 32'(res), 32'(tbl[v].exp));
      chk($sformatf("vec%0d_latency", v), 32'(cyc), 32'(tbl[v].n + 1));
      chk($sformatf("vec%0d_count", v), 32'(cnt), 32'(tbl[v].n));
    end

    // stalls in cycles 2,3,5 then 5 cycles of backpressure
    @(negedge clk); start = 1'b1; len = 8'd3;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 16'h3C00;
    @(negedge clk); in_valid = 1'b0;
    chk("stall_c2_acc", 32'(out_data), 32'h3C00);
    @(negedge clk);
    chk("stall_c3_acc", 32'(out_data), 32'h3C00);
    chk("stall_c3_count", 32'(count), 32'd1);
    in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    chk("stall_c5_acc", 32'(out_data), 32'h4000);
    @(negedge clk); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_data", i), 32'(out_data), 32'h4200);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk("bp_release", 32'(out_valid), 32'd0);

    // start pulses in ACCUM and DONE are ignored
    @(negedge clk); start = 1'b1; len = 8'd2;
    @(negedge clk); len = 8'd5; in_valid = 1'b1; in_data = 16'h3C00;
    @(negedge clk); len = 8'd7;
    @(negedge clk); in_valid = 1'b0; len = 8'd9;
    chk("ign_valid", 32'(out_valid), 32'd1);
    chk("ign_count", 32'(count), 32'd2);
    chk("ign_data", 32'(out_data), 32'h4000);
    @(negedge clk); start = 1'b0;
    chk("ign_done_valid", 32'(out_valid), 32'd1);
    chk("ign_done_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk("ign_busy", 32'(busy), 32'd0);

    // abort after two beats, beat in abort cycle is dropped
    @(negedge clk); start = 1'b1; len = 8'd4;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 16'h3C00;
    @(negedge clk);
    @(negedge clk); abort = 1'b1; in_data = 16'h4000;
    @(negedge clk); abort = 1'b0; in_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_acc", 32'(out_data), 32'd0);
    terms[0] = 16'h4000;
    run_vec(1, 1'b0, res, cyc, cnt);
    chk("after_abort_data", 32'(res), 32'h4000);

    // reset while a result is pending
    @(negedge clk); start = 1'b1; len = 8'd1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 16'h3C00;
    @(negedge clk); in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);

    for (int v = 0; v < 5; v++) begin
      n = $urandom_range(1, 255);
      mexp = 16'h0000;
      for (int i = 0; i < n; i++) begin
        terms[i] = {1'($urandom_range(0, 1)), 5'($urandom_range(8, 20)),
                    10'($urandom_range(0, 1023))};
        mexp = m_add(mexp, terms[i]);
      end
      run_vec(n, 1'b1, res, cyc, cnt);
      chk($sformatf("rand%0d_data", v), 32'(res), 32'(mexp));
      chk($sformatf("rand%0d_count", v), 32'(cnt), 32'(n));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/float16_accum_ctrl.md
# float16_accum_ctrl

Sequencing controller that accumulates a vector of float16 terms through one instance of the team's combinational `float16_adder`. It accepts a start command with a vector length, then consumes one float16 term per accepted input beat and feeds the running sum back into the adder. When the vector is complete it holds the final sum on a valid/ready output. It sits after the product stage of the dot-product pipeline and turns the product stream into the final dot-product result.

## Interface
- `LEN_W`, default 8: width of the vector-length input and the element counter; maximum vector length is 2^LEN_W-1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  start command; sampled only in IDLE.
- `len`  in  LEN_W  number of terms to accumulate; sampled with `start`.
- `abort`  in  1  cancels an accumulation in ACCUM; ignored in other states.
- `busy`  out  1  high whenever state is not IDLE.
- `in_valid`  in  1  input term valid.
- `in_data`  in  16  float16 term.
- `in_ready`  out  1  high only in ACCUM.
- `out_valid`  out  1  high only in DONE.
- `out_data`  out  16  accumulated float16 sum; stable while `out_valid` is high.
- `out_ready`  in  1  consumer accepts the result.
- `count`  out  LEN_W  number of terms accepted so far in the current vector.

## Operation
- States: IDLE, ACCUM, DONE. Encoding is free.
- IDLE:
  - `start`=1 with `len`≠0 → ACCUM; `acc`←16'h0000, `count`←0, `len` latched.
  - `start`=1 with `len`=0 → DONE directly; `acc`←16'h0000.
- ACCUM:
  - Beat accepted when `in_valid && in_ready`. On a beat, `acc`←float16_adder(`acc`, `in_data`) and `count`←`count`+1.
  - When the beat brings `count` to the latched `len` → DONE.
- DONE: `out_data`=`acc`. `out_valid && out_ready` → IDLE.
- `abort` in ACCUM → IDLE next edge. No output is produced, `acc` is cleared to 0, and a beat accepted in the same cycle is discarded.
- `start` outside IDLE is ignored. The latched `len` does not change mid-vector.
- Arithmetic follows `float16_adder` exactly; this block adds no extra rounding or exception handling:
  - alignment truncates;
  - subnormal inputs and underflowed results become +0;
  - exact cancellation gives 16'h0000;
  - exponent overflow is not detected.
- The adder is instantiated once. Its operands are `acc` and `in_data` directly, and its output is registered only into `acc`.

## Timing
- Reset: state=IDLE; `acc`, `count` and `out_data` = 0; `busy`, `in_ready` and `out_valid` = 0.
- `rst` has priority over every other input in any state, including mid-vector and in DONE. A pending result is lost.
- `start` sampled at edge 0 → `in_ready`=1 from cycle 1.
- With `in_valid` held high, beats are accepted in cycles 1..N, `out_valid`=1 from cycle N+1, and `in_ready`=0 from cycle N+1.
- Throughput: one term per cycle. Gaps in `in_valid` stall the accumulation without changing `acc`.
- `len`=0: `out_valid`=1 at cycle 1 with `out_data`=16'h0000.
- `out_valid` and `out_data` are held until `out_ready`. After the handshake edge, `out_valid`=0 and `busy`=0.
- A new `start` can be accepted at the earliest one cycle after the output handshake.
- `count` saturates at `len` by construction, with no wrap within a vector. `count` holds its value in DONE and clears on the next accepted `start`.

## Test plan
- Sum of four terms: reset, then `start`, `len`=4, stream 3C00, 4000, 4200, 3800 back-to-back with `out_ready`=1 → `out_valid` at cycle 5, `out_data`=16'h4680 (6.5).
- Cancellation: `len`=2, terms 3C00 then BC00 → `out_data`=16'h0000. Then `len`=1, term 8001 (subnormal) → 16'h0000.
- Stalls and backpressure: `len`=3, terms 3C00 in cycles 1, 4 and 6 with `in_valid` low otherwise, then `out_ready` low for 5 cycles → `acc` unchanged during gaps, final 16'h4200 held stable with `out_valid`=1 until `out_ready` goes high.
- Zero length and ignored start:
  - `len`=0 → `out_valid` at cycle 1 with 16'h0000.
  - `start` pulsed during ACCUM and DONE → no effect on `len`, `count` or result.
- Abort and reset mid-operation:
  - `len`=4, `abort` after 2 beats → IDLE, no `out_valid`.
  - Next vector `len`=1 with 4000 → 16'h4000.
  - `rst` asserted in DONE → all outputs at reset values on the next cycle.
- Random regression: random lengths 1..255 and random normal float16 terms with random `in_valid` gaps → `out_data` equals a sequential fold of a `float16_adder` model starting from 0; `count` equals the number of accepted beats.
